// File: rtl/tx_hs_serializer_if.sv
// PPI-side bundle of the HS serializer: byte handshake, DDR bit pair, stage enable
// and FSM debug taps. The serializer connects through the slave modport.
`timescale 1ns/1ps

// Handshake: the master holds TxRequestHS high for the whole burst and keeps TxDataHS
// valid; a byte is consumed on the rising edge where TxReadyHS=1 and TxRequestHS=1.
interface tx_hs_serializer_if;
    logic       TxRequestHS;
    logic [7:0] TxDataHS;
    logic       TxReadyHS;
    logic       serial_B1;
    logic       serial_B2;
    logic       deff_en;
    logic [1:0] dbg_state;
    logic [1:0] dbg_pair_cnt;

    modport master (
        output TxRequestHS,
        output TxDataHS,
        input  TxReadyHS,
        input  serial_B1,
        input  serial_B2,
        input  deff_en,
        input  dbg_state,
        input  dbg_pair_cnt
    );

    modport slave (
        input  TxRequestHS,
        input  TxDataHS,
        output TxReadyHS,
        output serial_B1,
        output serial_B2,
        output deff_en,
        output dbg_state,
        output dbg_pair_cnt
    );
endinterface

// File: rtl/tx_hs_serializer.sv
// HS serializer: sync byte plus payload bytes as two bits per DDR clock cycle.
// Optional trailer of TRAIL_BYTES byte times is built when TX_HS_TRAIL_EN is defined.
`timescale 1ns/1ps

module tx_hs_serializer #(
    parameter logic [7:0] SYNC_WORD = 8'hB8
`ifdef TX_HS_TRAIL_EN
    ,
    parameter int unsigned TRAIL_BYTES = 2
`endif
) (
    input  logic              TxDDRClkHS,
    input  logic              TxRst_n,
    tx_hs_serializer_if.slave ppi
);

`ifdef TX_HS_TRAIL_EN
    localparam int unsigned TRAIL_CYCLES = TRAIL_BYTES * 4;
    localparam int unsigned TRAIL_CW     = (TRAIL_CYCLES > 2) ? $clog2(TRAIL_CYCLES) : 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2
`ifdef TX_HS_TRAIL_EN
        ,
        TRAIL = 2'd3
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] pair_q, pair_d;
    logic [7:0] shift_q, shift_d;
    logic       b1_q, b1_d;
    logic       b2_q, b2_d;
    logic       deff_q, deff_d;
    logic       ready;
`ifdef TX_HS_TRAIL_EN
    logic [TRAIL_CW-1:0] trail_cnt_q, trail_cnt_d;
    logic                last_bit_q, last_bit_d;
`endif

    // Byte boundary: decoded from registered state so no input reaches TxReadyHS.
    assign ready = ((state_q == SYNC) || (state_q == DATA)) && (pair_q == 2'd3);

    always_ff @(posedge TxDDRClkHS or negedge TxRst_n) begin
        if (!TxRst_n) begin
            state_q     <= IDLE;
            pair_q      <= 2'd0;
            shift_q     <= 8'd0;
            b1_q        <= 1'b0;
            b2_q        <= 1'b0;
            deff_q      <= 1'b0;
`ifdef TX_HS_TRAIL_EN
            trail_cnt_q <= '0;
            last_bit_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pair_q      <= pair_d;
            shift_q     <= shift_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            deff_q      <= deff_d;
`ifdef TX_HS_TRAIL_EN
            trail_cnt_q <= trail_cnt_d;
            last_bit_q  <= last_bit_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pair_d      = pair_q;
        shift_d     = shift_q;
`ifdef TX_HS_TRAIL_EN
        trail_cnt_d = trail_cnt_q;
        last_bit_d  = last_bit_q;
`endif
        case (state_q)
            IDLE: begin
                pair_d = 2'd0;
                if (ppi.TxRequestHS) begin
                    state_d = SYNC;
                    shift_d = SYNC_WORD;
                end
            end
            SYNC, DATA: begin
                pair_d  = pair_q + 2'd1;
                shift_d = {2'b00, shift_q[7:2]};
                // The request is only looked at on the last pair of a byte.
                if (pair_q == 2'd3) begin
                    if (ppi.TxRequestHS) begin
                        state_d = DATA;
                        shift_d = ppi.TxDataHS;
                    end else if (state_q == DATA) begin
`ifdef TX_HS_TRAIL_EN
                        state_d     = TRAIL;
                        trail_cnt_d = TRAIL_CW'(TRAIL_CYCLES - 1);
                        last_bit_d  = shift_q[1];
`else
                        state_d     = IDLE;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef TX_HS_TRAIL_EN
            TRAIL: begin
                if (trail_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    trail_cnt_d = trail_cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                pair_d  = 2'd0;
            end
        endcase
    end

    // Output stage lags the state by one cycle; IDLE drives a quiet line.
    always_comb begin
        b1_d   = 1'b0;
        b2_d   = 1'b0;
        deff_d = 1'b0;
        case (state_q)
            SYNC, DATA: begin
                b1_d   = shift_q[0];
                b2_d   = shift_q[1];
                deff_d = 1'b1;
            end
`ifdef TX_HS_TRAIL_EN
            TRAIL: begin
                b1_d   = ~last_bit_q;
                b2_d   = ~last_bit_q;
                deff_d = 1'b1;
            end
`endif
            default: begin
                b1_d   = 1'b0;
                b2_d   = 1'b0;
                deff_d = 1'b0;
            end
        endcase
    end

    assign ppi.TxReadyHS    = ready;
    assign ppi.serial_B1    = b1_q;
    assign ppi.serial_B2    = b2_q;
    assign ppi.deff_en      = deff_q;
    assign ppi.dbg_state    = state_q;
    assign ppi.dbg_pair_cnt = pair_q;

endmodule

// File: tb/tb_tx_hs_serializer.sv
// Bench for tx_hs_serializer: directed and random bursts compared cycle by cycle
// against an on-wire bit stream model built from the burst contents.
`timescale 1ns/1ps

module tb_tx_hs_serializer;
    localparam int TRAIL_BYTES = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    logic [7:0] burst_q[$];
    logic [2:0] exp_q[$];

    tx_hs_serializer_if ppi_if ();

    tx_hs_serializer #(
        .SYNC_WORD(8'hB8)
`ifdef TX_HS_TRAIL_EN
        ,
        .TRAIL_BYTES(TRAIL_BYTES)
`endif
    ) dut (
        .TxDDRClkHS(clk),
        .TxRst_n   (rst_n),
        .ppi       (ppi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {deff_en, serial_B2, serial_B1} per cycle, from the on-wire bit order.
    task automatic build_expected();
        logic [7:0] sync_word;
        logic [7:0] b;
        logic       wb[$];
        sync_word = 8'hB8;
        for (int i = 0; i < 8; i++) wb.push_back(sync_word[i]);
        foreach (burst_q[j]) begin
            b = burst_q[j];
            for (int i = 0; i < 8; i++) wb.push_back(b[i]);
        end
`ifdef TX_HS_TRAIL_EN
        if (burst_q.size() > 0) begin
            b = burst_q[burst_q.size() - 1];
            for (int i = 0; i < TRAIL_BYTES * 8; i++) wb.push_back(~b[7]);
        end
`endif
        exp_q.delete();
        exp_q.push_back(3'b000);
        for (int i = 0; i < wb.size(); i += 2) exp_q.push_back({1'b1, wb[i + 1], wb[i]});
        exp_q.push_back(3'b000);
    endtask

    // Sends burst_q as one burst; call just after a rising edge with the DUT idle.
    task automatic run_burst(input string name, input int drop_d, input bit glitch);
        int   n;
        int   idx;
        int   since;
        int   pulses;
        int   accepts;
        int   rdy_end;
        logic rdy_s;
        n       = burst_q.size();
        idx     = 0;
        since   = 0;
        pulses  = 0;
        accepts = 0;
        rdy_end = 4 * (n + 1);
        build_expected();
        ppi_if.TxRequestHS = 1'b1;
        ppi_if.TxDataHS    = (n > 0) ? burst_q[0] : 8'($urandom);
        @(negedge clk);
        rdy_s = ppi_if.TxReadyHS;
        check({name, "/ready_idle"}, 32'(rdy_s), 32'(0));
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk);
            if (rdy_s) pulses++;
            since++;
            if (rdy_s && ppi_if.TxRequestHS) begin
                accepts++;
                idx++;
                since = 0;
            end
            #1;
            if (n == 0)                    ppi_if.TxRequestHS = 1'b0;
            else if (idx >= n)             ppi_if.TxRequestHS = (since < drop_d);
            else if (idx > 0 && glitch)    ppi_if.TxRequestHS = (since != 1);
            else                           ppi_if.TxRequestHS = 1'b1;
            ppi_if.TxDataHS = (idx < n) ? burst_q[idx] : 8'($urandom);
            @(negedge clk);
            check($sformatf("%s/trace[%0d]", name, k),
                  32'({ppi_if.deff_en, ppi_if.serial_B2, ppi_if.serial_B1}), 32'(exp_q[k]));
            rdy_s = ppi_if.TxReadyHS;
            check($sformatf("%s/ready[%0d]", name, k), 32'(rdy_s),
                  32'((k < rdy_end) && (k % 4 == 3)));
            if (k < rdy_end)
                check($sformatf("%s/pair[%0d]", name, k), 32'(ppi_if.dbg_pair_cnt), 32'(k % 4));
        end
        check({name, "/ready_pulses"}, 32'(pulses), 32'(n + 1));
        check({name, "/accepted"}, 32'(accepts), 32'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "/serial"}, 32'({ppi_if.serial_B2, ppi_if.serial_B1}), 32'(0));
        check({tag, "/deff_en"}, 32'(ppi_if.deff_en), 32'(0));
        check({tag, "/ready"}, 32'(ppi_if.TxReadyHS), 32'(0));
        check({tag, "/pair"}, 32'(ppi_if.dbg_pair_cnt), 32'(0));
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b1;
        ppi_if.TxRequestHS = 1'b0;
        ppi_if.TxDataHS    = 8'h00;
        #2 rst_n = 1'b0;
        #1 check_quiet("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_quiet("post_reset_idle");

        burst_q = '{8'hA5};
        run_burst("a5", 0, 1'b0);
        burst_q = '{8'h00, 8'hFF, 8'h3C};
        run_burst("three", 0, 1'b0);
        burst_q = '{8'h80};
        run_burst("last80", 0, 1'b0);
        burst_q = '{8'h01};
        run_burst("last01", 0, 1'b0);
        burst_q = '{8'h11, 8'h22};
        run_burst("drop_p1", 1, 1'b0);
        burst_q = '{8'h5A, 8'hC3, 8'h96};
        run_burst("glitch", 3, 1'b1);
        burst_q.delete();
        run_burst("empty", 0, 1'b0);

        // Abort in DATA pair 2 of the first payload byte, request held throughout.
        ppi_if.TxRequestHS = 1'b1;
        ppi_if.TxDataHS    = 8'hE7;
        repeat (7) @(posedge clk);
        #1 check("abort/pair_before", 32'(ppi_if.dbg_pair_cnt), 32'(2));
        check("abort/deff_before", 32'(ppi_if.deff_en), 32'(1));
        #1 rst_n = 1'b0;
        #1 check_quiet("abort");
        @(posedge clk);
        #1 check_quiet("abort_hold");
        rst_n = 1'b1;
        burst_q = '{8'hC3};
        run_burst("after_abort", 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int n;
            burst_q.delete();
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom));
            run_burst($sformatf("rnd%0d", r), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
